// File: rtl/keypad_event_debounce.sv
// Keypad event debouncer: two-flop synchroniser, press/release debounce FSM and
// a small first-word-fall-through event FIFO toward the vending-machine controller.
module keypad_event_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned CNT_W           = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [3:0]                    key_raw,
  output logic                          evt_valid,
  output logic [3:0]                    evt_code,
  input  logic                          evt_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          key_held,
  output logic                          overflow,
  input  logic                          clear_overflow
);

  localparam int unsigned       PW         = $clog2(FIFO_DEPTH);
  localparam int unsigned       CW         = PW + 1;
  localparam logic [CNT_W-1:0]  CNT_LIMIT  = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]     FULL_COUNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, CAND, PRESSED, REL} state_t;

  logic [3:0]       sync1_q, sync2_q;
  state_t           state_q, state_d;
  logic [3:0]       cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             push;

  logic [3:0]       mem_q [FIFO_DEPTH];
  logic [3:0]       mem_d [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             pop, full, do_push, drop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= key_raw;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cand_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    push    = 1'b0;
    cnt_inc = cnt_q + CNT_W'(1);
    case (state_q)
      IDLE: begin
        if (sync2_q != '0) begin
          state_d = CAND;
          cand_d  = sync2_q;
          cnt_d   = CNT_W'(1);
        end
      end
      CAND: begin
        if (sync2_q == cand_q) begin
          if (cnt_inc == CNT_LIMIT) begin
            push    = 1'b1;
            state_d = PRESSED;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end else if (sync2_q == '0) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cand_d = sync2_q;
          cnt_d  = CNT_W'(1);
        end
      end
      PRESSED: begin
        if (sync2_q != cand_q) begin
          state_d = REL;
          cnt_d   = CNT_W'(1);
        end
      end
      REL: begin
        // Any code other than the held one, including a different key, counts as release.
        if (sync2_q == cand_q) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_inc == CNT_LIMIT) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    key_held = (state_q == PRESSED) || (state_q == REL);
  end

  always_comb begin
    evt_valid  = (count_q != '0);
    evt_code   = evt_valid ? mem_q[rd_ptr_q] : '0;
    fifo_count = count_q;
    overflow   = overflow_q;
    pop        = evt_valid && evt_ready;
    full       = (count_q == FULL_COUNT);
    // When full, a same-cycle pop frees the head slot, which is where wr_ptr points.
    do_push    = push && (!full || pop);
    drop       = push && full && !pop;

    mem_d = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = cand_q;
    end
    wr_ptr_d = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;

    case ({do_push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (drop) begin
      overflow_d = 1'b1;
    end else if (clear_overflow) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_q      <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: doc/keypad_event_debounce.md
Name: keypad_event_debounce

Overview:
- Sits directly downstream of the 4x4 keypad scanner and consumes its 4-bit key code (0 = no key).
- Synchronises and debounces the code, then emits exactly one event per debounced press.
- Holds events in a small first-word-fall-through (FWFT) FIFO with a valid/ready handshake toward the vending-machine control FSM.
- Release must also be debounced before a new press is accepted.

Parameters:
- DEBOUNCE_CYCLES, 16, consecutive identical synchronised samples needed to accept a press or a release (range 2..65535).
- FIFO_DEPTH, 4, event FIFO entries (power of two, minimum 2).
- CNT_W, 16, width of the debounce counter.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- key_raw  input  4  key code from the scanner; 0 = no key
- evt_valid  output  1  FIFO non-empty; an event is presented
- evt_code  output  4  key code of the head event; 0 when empty
- evt_ready  input  1  consumer accepts the head event
- fifo_count  output  $clog2(FIFO_DEPTH)+1  entries currently stored
- key_held  output  1  a debounced key is currently held
- overflow  output  1  sticky: an event was dropped
- clear_overflow  input  1  clears overflow

Behaviour:
- Reset (asynchronous, active-low):
  - clears the synchroniser, FSM (IDLE), counter, candidate code, FIFO pointers and count;
  - evt_valid=0, evt_code=0, fifo_count=0, key_held=0, overflow=0.
  - A key still held when reset deasserts produces one fresh event after a full debounce.
- Synchroniser: key_raw passes through two flops (sync1 -> sync2). All decisions use sync2.
- FSM, with candidate register cand and counter cnt:
  - IDLE: sync2!=0 -> CAND, cand=sync2, cnt=1.
  - CAND:
    - sync2==cand: cnt+1. When the incremented value equals DEBOUNCE_CYCLES, push cand into the FIFO and go to PRESSED, cnt=0.
    - sync2==0: -> IDLE, cnt=0.
    - sync2 nonzero and !=cand: stay in CAND, cand=sync2, cnt=1 (restart).
  - PRESSED: key_held=1. If sync2!=cand -> REL, cnt=1.
  - REL: key_held=1.
    - sync2==cand: -> PRESSED, cnt=0 (bounce on release).
    - Otherwise cnt+1; on reaching DEBOUNCE_CYCLES -> IDLE, cnt=0.
    - A different nonzero key counts as release; it produces no event until the FSM returns to IDLE and debounces it afresh.
- Latency: count the edge that first samples a new stable key_raw as edge 1. The push occurs at edge DEBOUNCE_CYCLES+2, and evt_valid is high immediately after it. Holding a key produces no further events; there is no auto-repeat.
- FIFO:
  - FWFT: evt_code shows the head entry whenever evt_valid=1.
  - Pop when evt_valid && evt_ready.
  - Push when not full: entry stored, fifo_count+1.
  - Push when full with no pop: event dropped, overflow set, contents unchanged.
  - Push and pop in the same cycle (including when full): both occur, fifo_count unchanged, no overflow.
  - Pop when empty: ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- overflow: set wins over clear_overflow in the same cycle; otherwise clear_overflow drives it to 0 on the next edge.
- evt_ready may be held high continuously; one event is consumed per cycle.
- evt_code and evt_valid must be stable while evt_valid=1 and evt_ready=0.

Test Plan:
- DEBOUNCE_CYCLES=16: key_raw 0->4'h1, held 40 cycles, then 0; evt_ready=1 -> evt_valid high one cycle after edge 18 with evt_code=1, single pulse only. key_held falls 17 edges after release.
- Key 4'h1 glitching every 5 cycles for 50 cycles, then stable -> no event during glitching; exactly one event after 16+2 stable edges.
- Release bounce: held key drops to 0 for 6 cycles, returns for 10 cycles, then 0 -> no second event; key_held stays 1 until 16 consecutive release samples.
- evt_ready=0, five distinct debounced presses 1,2,3,4,5 -> fifo_count=4, overflow=1. Then evt_ready=1 -> codes 1,2,3,4 in order on consecutive cycles, evt_valid drops. clear_overflow -> overflow=0.
- FIFO full with evt_ready=1 in the same cycle a new press is accepted -> fifo_count stays 4, overflow stays 0, new code is last out.
- Assert reset mid-CAND (cnt=10) and again with 2 FIFO entries pending -> all outputs 0 immediately. Key held through reset release -> one event after the full debounce.
